// File: rtl/gsm_at_sequencer_if.sv
// Bus between the script owner (key/alarm logic, command memory, modem RX) and gsm_at_sequencer.
// master = script owner side, slave = sequencer side.
interface gsm_at_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [9:0]        rom_data;
    logic              uart_rx;
    logic              uart_tx;
    logic              busy;
    logic              done;
    logic              error;
    logic [7:0]        cmd_idx;

    modport master (
        output start, rom_data, uart_rx,
        input  rom_addr, uart_tx, busy, done, error, cmd_idx
    );

    modport slave (
        input  start, rom_data, uart_rx,
        output rom_addr, uart_tx, busy, done, error, cmd_idx
    );
endinterface

// File: rtl/gsm_at_sequencer.sv
// Walks a command memory and sends each byte as 8N1 UART, idling GAP_CYCLES after each command.
// `GSM_RESP_CHECK_EN: instead of the gap, wait for "OK\r" from the modem and resend on timeout.
module gsm_at_sequencer #(
    parameter int unsigned CLK_DIV        = 2500,
    parameter int unsigned GAP_CYCLES     = 12000000,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 24000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input logic               clk,
    input logic               rst,
    gsm_at_sequencer_if.slave bus
);
    localparam int unsigned DivW = $clog2(CLK_DIV + 1);
    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LastAddr = '1;

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StSend, StGap, StResp} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [8:0]        shift_q;
    logic              eos_q;
    logic              eoc_q;
    logic [DivW-1:0]   div_q;
    logic [3:0]        bit_q;
    logic [GapW-1:0]   gap_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [7:0]        cmd_idx_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef GSM_RESP_CHECK_EN
    localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

    logic [ADDR_W-1:0] cmd_start_q;
    logic [TmoW-1:0]   tmo_q;
    logic [RetryW-1:0] retry_q;
    logic [1:0]        match_q;
    logic [7:0]        expect_byte;

    logic              rx_s1_q;
    logic              rx_s2_q;
    logic              rx_busy_q;
    logic [DivW-1:0]   rx_cnt_q;
    logic [3:0]        rx_bit_q;
    logic [7:0]        rx_sh_q;
    logic              rx_valid_q;
    logic [7:0]        rx_byte_q;

    assign expect_byte = (match_q == 2'd0) ? 8'h4F : (match_q == 2'd1) ? 8'h4B : 8'h0D;

    // Receiver: rx_bit_q 0 = start bit (sampled half a bit in), 1..8 data, 9 stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            rx_s1_q    <= bus.uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_valid_q <= 1'b0;
            if (!rx_busy_q) begin
                if (!rx_s2_q) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= '0;
                    rx_bit_q  <= '0;
                end
            end else if (rx_cnt_q == ((rx_bit_q == 4'd0) ? DivW'(CLK_DIV / 2 - 1)
                                                         : DivW'(CLK_DIV - 1))) begin
                rx_cnt_q <= '0;
                if (rx_bit_q == 4'd0) begin
                    if (rx_s2_q) rx_busy_q <= 1'b0;
                    else         rx_bit_q  <= 4'd1;
                end else if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    if (rx_s2_q) begin
                        rx_valid_q <= 1'b1;
                        rx_byte_q  <= rx_sh_q;
                    end
                end else begin
                    rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_q <= rx_bit_q + 4'd1;
                end
            end else begin
                rx_cnt_q <= rx_cnt_q + DivW'(1);
            end
        end
    end
`else
    logic unused_rx;
    assign unused_rx = ^{bus.uart_rx, TIMEOUT_CYCLES[0], MAX_RETRY[0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            shift_q   <= '1;
            eos_q     <= 1'b0;
            eoc_q     <= 1'b0;
            div_q     <= '0;
            bit_q     <= '0;
            gap_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cmd_idx_q <= '0;
`ifdef GSM_RESP_CHECK_EN
            cmd_start_q <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            match_q     <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        addr_q    <= '0;
                        busy_q    <= 1'b1;
                        cmd_idx_q <= '0;
                        state_q   <= StFetch;
`ifdef GSM_RESP_CHECK_EN
                        cmd_start_q <= '0;
                        retry_q     <= '0;
`endif
                    end
                end
                StFetch: state_q <= StLoad;
                StLoad: begin
                    shift_q <= {1'b1, bus.rom_data[7:0]};
                    eos_q   <= bus.rom_data[9];
                    eoc_q   <= bus.rom_data[8];
                    tx_q    <= 1'b0;
                    div_q   <= '0;
                    bit_q   <= '0;
                    state_q <= StSend;
                end
                StSend: begin
                    if (div_q != DivW'(CLK_DIV - 1)) begin
                        div_q <= div_q + DivW'(1);
                    end else if (bit_q != 4'd9) begin
                        div_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b1, shift_q[8:1]};
                        bit_q   <= bit_q + 4'd1;
                    end else if (eos_q) begin
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        cmd_idx_q <= sat_inc(cmd_idx_q);
                        state_q   <= StIdle;
                    end else if (addr_q == LastAddr) begin
                        // Script ran off the end of memory without an end-of-script byte.
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (eoc_q) begin
                        addr_q <= addr_q + ADDR_W'(1);
`ifdef GSM_RESP_CHECK_EN
                        cmd_start_q <= addr_q + ADDR_W'(1);
                        tmo_q       <= '0;
                        match_q     <= '0;
                        state_q     <= StResp;
`else
                        cmd_idx_q <= sat_inc(cmd_idx_q);
                        gap_q     <= '0;
                        state_q   <= StGap;
`endif
                    end else begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= StFetch;
                    end
                end
                StGap: begin
                    if (gap_q == GapW'(GAP_CYCLES - 1)) state_q <= StFetch;
                    else                                gap_q   <= gap_q + GapW'(1);
                end
`ifdef GSM_RESP_CHECK_EN
                StResp: begin
                    if (rx_valid_q && match_q == 2'd2 && rx_byte_q == 8'h0D) begin
                        retry_q   <= '0;
                        cmd_idx_q <= sat_inc(cmd_idx_q);
                        state_q   <= StFetch;
                    end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                        if (retry_q >= RetryW'(MAX_RETRY)) begin
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            retry_q <= retry_q + RetryW'(1);
                            addr_q  <= cmd_start_q;
                            state_q <= StFetch;
                        end
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                        // A stray "O" restarts the match rather than dropping it.
                        if (rx_valid_q) begin
                            match_q <= (rx_byte_q == expect_byte) ? match_q + 2'd1 :
                                       (rx_byte_q == 8'h4F)       ? 2'd1 : 2'd0;
                        end
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.uart_tx  = tx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.cmd_idx  = cmd_idx_q;
endmodule

// File: tb/tb_gsm_at_sequencer.sv
// Self-checking bench for gsm_at_sequencer: table of command scripts plus reset, busy-start and
// (with GSM_RESP_CHECK_EN) response/retry sequences; a UART monitor scores frames against a queue.
module tb_gsm_at_sequencer;
    localparam int unsigned D   = 4;
    localparam int unsigned GAP = 20;
    localparam int unsigned AW  = 3;
    localparam int unsigned TMO = 200;
    localparam int FRAME = 10 * D;
    localparam int NCASE = 7;

    typedef struct {
        logic [7:0] b;
        int         gap;
    } exp_t;

    typedef struct {
        logic [7:0][9:0] rom;
        bit              exp_done;
        int              exp_cmd;
        bit              has_eoc;
    } case_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] mem [8];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         frames = 0;
    int         last_start = 0;
    exp_t       exp_q[$];
    case_t      tbl[NCASE];

    gsm_at_sequencer_if #(.ADDR_W(AW)) bus ();

    gsm_at_sequencer #(
        .CLK_DIV       (D),
        .GAP_CYCLES    (GAP),
        .ADDR_W        (AW),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRY     (1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0][9:0] from_str(input string s, input int eoc_mask,
                                                 input int eos_at);
        logic [7:0][9:0] r = '0;
        for (int i = 0; i < s.len(); i++) r[i] = {(i == eos_at), eoc_mask[i], s[i]};
        return r;
    endfunction

    task automatic set_mem(input logic [7:0][9:0] r);
        for (int a = 0; a < 8; a++) mem[a] = r[a];
    endtask

    // Expected frames: first start bit 2 cycles after start, then frame + 2 idle (+ gap after eoc).
    task automatic push_script();
        int gap = 2;
        for (int a = 0; a < 8; a++) begin
            exp_q.push_back(exp_t'{mem[a][7:0], gap});
            if (mem[a][9]) break;
            gap = FRAME + 2 + (mem[a][8] ? GAP : 0);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        last_start = cyc;
    endtask

    task automatic wait_outcome(input bit exp_done, input int exp_cmd, input int lat,
                                input int poke);
        int n = 0;
        while (bus.done !== 1'b1 && bus.error !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
            bus.start = (n == poke);
        end
        bus.start = 1'b0;
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL outcome_timeout: no done/error after %0d cycles", n);
        end else begin
            check("done", bus.done, exp_done);
            check("error", bus.error, !exp_done);
            check("busy_at_end", bus.busy, 0);
            check("cmd_idx", bus.cmd_idx, exp_cmd);
            check("end_latency", cyc - last_start, lat);
            @(negedge clk);
            check("pulse_width", bus.done | bus.error, 0);
        end
        repeat (60) @(negedge clk);
        check("frames_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

`ifdef GSM_RESP_CHECK_EN
    task automatic send_rx(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus.uart_rx = (i < 10) ? f[i] : 1'b1;
            repeat (D) @(negedge clk);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_rx(s[i]);
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (frames < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (frames < n) begin
            checks++;
            failures++;
            $display("FAIL wait_frames: saw %0d frames, needed %0d", frames, n);
        end
    endtask
`endif

    initial begin : monitor
        logic       prev;
        logic [7:0] b;
        logic       stop_bit;
        bit         ab;
        int         t0;
        int         gap_seen;
        exp_t       e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && bus.uart_tx === 1'b0 && !rst) begin
                t0 = cyc;
                gap_seen = t0 - last_start;
                last_start = t0;
                ab = 1'b0;
                b = '0;
                stop_bit = 1'b0;
                for (int k = 1; k <= 39; k++) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                    if (k >= 6 && k <= 34 && k % 4 == 2) b[(k - 6) / 4] = bus.uart_tx;
                    if (k == 38) stop_bit = bus.uart_tx;
                end
                if (!ab) begin
                    frames++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_frame: got byte 0x%02h, expected none", b);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", b, e.b);
                        check("stop_bit", stop_bit, 1);
                        if (e.gap > 0) check("start_spacing", gap_seen, e.gap);
                    end
                end
            end
            prev = bus.uart_tx;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int ri;
        int f0;
        bus.start   = 1'b0;
        bus.uart_rx = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = '0;

        tbl[0] = '{from_str("AT\015Z", 'b0100, 3), 1'b1, 2, 1'b1};
        tbl[1] = '{from_str("Q", 0, 0), 1'b1, 1, 1'b0};
        tbl[2] = '{from_str("01234567", 0, -1), 1'b0, 0, 1'b0};
        tbl[3] = '{from_str("ABCDEFGH", 0, 7), 1'b1, 1, 1'b0};
        tbl[4] = '{from_str("XYZ", 'b011, 2), 1'b1, 3, 1'b1};
        tbl[5] = '{from_str("abcdefgh", 'b01000000, 7), 1'b1, 2, 1'b1};
        tbl[6] = '{from_str("AT\015Z", 0, 3), 1'b1, 1, 1'b0};
        ri = 0;
`ifdef GSM_RESP_CHECK_EN
        ri = 6;
`endif

        repeat (3) @(negedge clk);
        check("rst_uart_tx", bus.uart_tx, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_rom_addr", bus.rom_addr, 0);
        check("rst_cmd_idx", bus.cmd_idx, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NCASE; i++) begin
`ifdef GSM_RESP_CHECK_EN
            if (tbl[i].has_eoc) continue;
`endif
            set_mem(tbl[i].rom);
            push_script();
            pulse_start();
            wait_outcome(tbl[i].exp_done, tbl[i].exp_cmd, FRAME, 0);
        end

        // start while busy must not restart the script
        set_mem(tbl[ri].rom);
        push_script();
        pulse_start();
        wait_outcome(1'b1, tbl[ri].exp_cmd, FRAME, 50);

        // reset in the middle of the 0x54 frame, then replay from "A"
        set_mem(tbl[ri].rom);
        push_script();
        pulse_start();
        repeat (60) @(negedge clk);
        check("pre_rst_tx_low", bus.uart_tx, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_uart_tx", bus.uart_tx, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_rom_addr", bus.rom_addr, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_frames_left", exp_q.size(), 3);
        exp_q.delete();
        push_script();
        pulse_start();
        wait_outcome(1'b1, tbl[ri].exp_cmd, FRAME, 0);

`ifdef GSM_RESP_CHECK_EN
        // OK on command 1, silence on command 2: command 2 sent twice, then error
        set_mem(from_str("ABC", 'b011, 2));
        f0 = frames;
        exp_q.push_back(exp_t'{8'h41, 2});
        exp_q.push_back(exp_t'{8'h42, 0});
        exp_q.push_back(exp_t'{8'h42, FRAME + TMO + 2});
        pulse_start();
        wait_frames(f0 + 1);
        send_str("OK\015");
        wait_outcome(1'b0, 1, FRAME + TMO, 0);

        // "OOK\r" still matches
        set_mem(from_str("AC", 'b01, 1));
        exp_q.push_back(exp_t'{8'h41, 2});
        exp_q.push_back(exp_t'{8'h43, 0});
        pulse_start();
        wait_frames(frames + 1);
        send_str("OOK\015");
        wait_outcome(1'b1, 2, FRAME, 0);

        // "OX K\r" does not match: timeout resend, then OK lets the script finish
        f0 = frames;
        exp_q.push_back(exp_t'{8'h41, 2});
        exp_q.push_back(exp_t'{8'h41, FRAME + TMO + 2});
        exp_q.push_back(exp_t'{8'h43, 0});
        pulse_start();
        wait_frames(f0 + 1);
        send_str("OX K\015");
        wait_frames(f0 + 2);
        send_str("OK\015");
        wait_outcome(1'b1, 2, FRAME, 0);
`else
        f0 = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
